// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port GPR file and its snapshot streamer.
// wr_sel() resolves one address against all write ports; the highest-numbered port wins.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NUMREG_DEF = 32;
    localparam int NRD_DEF    = 3;
    localparam int NWR_DEF    = 2;

    // Write-port bundles are zero-padded to these bounds so one function serves any instance.
    localparam int WS_MAX_NWR  = 8;
    localparam int WS_MAX_AW   = 8;
    localparam int WS_MAX_XLEN = 64;

    typedef enum logic [1:0] {
        SNAP_IDLE = 2'd0,
        SNAP_LOAD = 2'd1,
        SNAP_BEAT = 2'd2
    } snap_state_e;

    typedef logic [WS_MAX_NWR-1:0]                  ws_we_t;
    typedef logic [WS_MAX_NWR-1:0][WS_MAX_AW-1:0]   ws_addr_t;
    typedef logic [WS_MAX_NWR-1:0][WS_MAX_XLEN-1:0] ws_data_t;

    typedef struct packed {
        logic                   hit;
        logic [WS_MAX_XLEN-1:0] data;
    } wr_sel_t;

    function automatic wr_sel_t wr_sel(input ws_we_t we, input ws_addr_t wa,
                                       input ws_data_t wd, input logic [WS_MAX_AW-1:0] addr);
        wr_sel_t r;
        r = '0;
        for (int p = 0; p < WS_MAX_NWR; p++) begin
            if (we[p] && (wa[p] == addr)) begin
                r.hit  = 1'b1;
                r.data = wd[p];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_snap_ctrl.sv
// Snapshot streamer: walks every register in index order, one valid/ready beat each,
// reading through a dedicated read port of the register file.
//   state     | meaning
//   SNAP_IDLE | no dump in progress, snap_req sampled here only
//   SNAP_LOAD | capture register idx into the beat holding registers
//   SNAP_BEAT | beat presented, wait for snap_ready
module regfile_snap_ctrl
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NUMREG = NUMREG_DEF,
    localparam int AW     = $clog2(NUMREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            snap_req,
    input  logic            snap_ready,
    output logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            snap_active,
    output logic            snap_valid,
    output logic [AW-1:0]   snap_idx,
    output logic [XLEN-1:0] snap_data,
    output logic            snap_last
);

    snap_state_e     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SNAP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            SNAP_IDLE: begin
                if (snap_req) begin
                    state_d = SNAP_LOAD;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end
            end
            SNAP_LOAD: begin
                data_d  = rd_data;
                last_d  = (idx_q == AW'(NUMREG - 1));
                state_d = SNAP_BEAT;
            end
            SNAP_BEAT: begin
                if (snap_ready) begin
                    if (last_q) begin
                        state_d = SNAP_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SNAP_LOAD;
                    end
                end
            end
            default: state_d = SNAP_IDLE;
        endcase
    end

    assign rd_addr     = idx_q;
    assign snap_active = (state_q != SNAP_IDLE);
    assign snap_valid  = (state_q == SNAP_BEAT);
    assign snap_idx    = idx_q;
    assign snap_data   = data_q;
    assign snap_last   = last_q;

endmodule

// File: rtl/regfile_mp_snap.sv
// Multi-port GPR file with scoreboard busy bits and a register snapshot streamer.
// Define REGFILE_BYPASS_EN for write-first reads (same-cycle writes forwarded); default is read-old.
module regfile_mp_snap
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NUMREG = NUMREG_DEF,
    parameter  int NRD    = NRD_DEF,
    parameter  int NWR    = NWR_DEF,
    localparam int AW     = $clog2(NUMREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_set_a,
    output logic [NUMREG-1:0]   busy,
    input  logic                snap_req,
    output logic                snap_active,
    output logic                snap_valid,
    input  logic                snap_ready,
    output logic [AW-1:0]       snap_idx,
    output logic [XLEN-1:0]     snap_data,
    output logic                snap_last
);

    ws_we_t   we_v;
    ws_addr_t wa_v;
    ws_data_t wd_v;

    logic [XLEN-1:0]   rf_q [NUMREG];
    logic [XLEN-1:0]   rf_d [NUMREG];
    logic [NUMREG-1:0] wr_hit;
    logic [NUMREG-1:0] busy_q, busy_d;

    // Port NRD is the snapshot streamer's private read port.
    logic [AW-1:0]     rp_addr [NRD+1];
    logic [XLEN-1:0]   rp_data [NRD+1];
    logic [AW-1:0]     snap_rd_addr;

    always_comb begin
        we_v = '0;
        wa_v = '0;
        wd_v = '0;
        for (int p = 0; p < NWR; p++) begin
            we_v[p] = we[p];
            wa_v[p] = WS_MAX_AW'(wa[p*AW +: AW]);
            wd_v[p] = WS_MAX_XLEN'(wd[p*XLEN +: XLEN]);
        end
    end

    always_comb begin
        wr_sel_t sel;
        sel    = '0;
        wr_hit = '0;
        for (int r = 0; r < NUMREG; r++) begin
            rf_d[r] = rf_q[r];
            sel     = wr_sel(we_v, wa_v, wd_v, WS_MAX_AW'(r));
            if ((r != 0) && sel.hit) begin
                rf_d[r]   = sel.data[XLEN-1:0];
                wr_hit[r] = 1'b1;
            end
        end
    end

    // Set is applied after clear so a same-cycle set on a written register keeps it busy.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (sb_set) begin
            busy_d[sb_set_a] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUMREG; r++) begin
                rf_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rp_addr[p] = ra[p*AW +: AW];
        end
        rp_addr[NRD] = snap_rd_addr;
    end

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        wr_sel_t fwd;
        fwd = '0;
`endif
        for (int p = 0; p <= NRD; p++) begin
            rp_data[p] = rf_q[rp_addr[p]];
`ifdef REGFILE_BYPASS_EN
            fwd = wr_sel(we_v, wa_v, wd_v, WS_MAX_AW'(rp_addr[p]));
            if (fwd.hit) begin
                rp_data[p] = fwd.data[XLEN-1:0];
            end
`endif
            if (rp_addr[p] == '0) begin
                rp_data[p] = '0;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int p = 0; p < NRD; p++) begin
            rd[p*XLEN +: XLEN] = rp_data[p];
        end
    end

    assign busy = busy_q;

    regfile_snap_ctrl #(
        .XLEN   (XLEN),
        .NUMREG (NUMREG)
    ) u_snap_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .snap_req    (snap_req),
        .snap_ready  (snap_ready),
        .rd_addr     (snap_rd_addr),
        .rd_data     (rp_data[NRD]),
        .snap_active (snap_active),
        .snap_valid  (snap_valid),
        .snap_idx    (snap_idx),
        .snap_data   (snap_data),
        .snap_last   (snap_last)
    );

endmodule

// File: tb/tb_regfile_mp_snap.sv
// Directed bench for regfile_mp_snap: table of write/read/scoreboard cycles, then
// snapshot dump (random stalls, live write, ignored re-request) and reset abort.
module tb_regfile_mp_snap;

    localparam int XLEN   = 32;
    localparam int NUMREG = 32;
    localparam int NRD    = 3;
    localparam int NWR    = 2;
    localparam int AW     = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NWR-1:0]      we;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic [AW-1:0]       ra0, ra1, ra2;
    logic [NRD*XLEN-1:0] rd;
    logic                sb_set;
    logic [AW-1:0]       sb_set_a;
    logic [NUMREG-1:0]   busy;
    logic                snap_req, snap_active, snap_valid, snap_ready, snap_last;
    logic [AW-1:0]       snap_idx;
    logic [XLEN-1:0]     snap_data;

    regfile_mp_snap #(.XLEN(XLEN), .NUMREG(NUMREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wa          ({wa1, wa0}),
        .wd          ({wd1, wd0}),
        .ra          ({ra2, ra1, ra0}),
        .rd          (rd),
        .sb_set      (sb_set),
        .sb_set_a    (sb_set_a),
        .busy        (busy),
        .snap_req    (snap_req),
        .snap_active (snap_active),
        .snap_valid  (snap_valid),
        .snap_ready  (snap_ready),
        .snap_idx    (snap_idx),
        .snap_data   (snap_data),
        .snap_last   (snap_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        sb;
        logic [4:0]  sba;
        logic [4:0]  ra0;
        logic [31:0] exp_old, exp_byp;
        logic [4:0]  ra1;
        logic [31:0] exp_rd1;
        logic [31:0] exp_busy;
    } vec_t;

    localparam logic [31:0] VA = 32'hAAAA0001;
    localparam logic [31:0] VB = 32'hBBBB0002;

    vec_t        vt [14];
    logic [31:0] exp_rf [NUMREG];

    initial begin
        int   beats, cyc, port;
        bit   prev_valid, prev_hs, hs, live_done, req2_done, reached;
        logic [AW-1:0]   p_idx;
        logic [XLEN-1:0] p_data;
        logic            p_last;
        logic [31:0]     e0;

        //          we     wa0   wa1   wd0           wd1    sb   sba   ra0   old        byp        ra1   rd1        busy
        vt[0]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd0, 32'h0,     32'h0,     5'd0, 32'h0,     32'h0};
        vt[1]  = '{2'b11, 5'd5, 5'd5, VA,           VB,    1'b0, 5'd0, 5'd5, 32'h0,     VB,        5'd1, 32'h0,     32'h0};
        vt[2]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd5, VB,        VB,        5'd5, VB,        32'h0};
        vt[3]  = '{2'b01, 5'd0, 5'd0, 32'hDEAD,     32'h0, 1'b0, 5'd0, 5'd0, 32'h0,     32'h0,     5'd5, VB,        32'h0};
        vt[4]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd0, 32'h0,     32'h0,     5'd5, VB,        32'h0};
        vt[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b1, 5'd3, 5'd3, 32'h0,     32'h0,     5'd5, VB,        32'h0};
        vt[6]  = '{2'b01, 5'd3, 5'd0, 32'h33,       32'h0, 1'b0, 5'd0, 5'd3, 32'h0,     32'h33,    5'd5, VB,        32'h8};
        vt[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd3, 32'h33,    32'h33,    5'd3, 32'h33,    32'h0};
        vt[8]  = '{2'b10, 5'd0, 5'd3, 32'h0,        32'h44,1'b1, 5'd3, 5'd3, 32'h33,    32'h44,    5'd5, VB,        32'h0};
        vt[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd3, 32'h44,    32'h44,    5'd3, 32'h44,    32'h8};
        vt[10] = '{2'b11, 5'd7, 5'd9, 32'h1234,     32'h99,1'b1, 5'd0, 5'd7, 32'h0,     32'h1234,  5'd5, VB,        32'h8};
        vt[11] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd9, 32'h99,    32'h99,    5'd7, 32'h1234,  32'h8};
        vt[12] = '{2'b11, 5'd3, 5'd6, 32'h55,       32'h66,1'b0, 5'd0, 5'd3, 32'h44,    32'h55,    5'd9, 32'h99,    32'h8};
        vt[13] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 1'b0, 5'd0, 5'd6, 32'h66,    32'h66,    5'd3, 32'h55,    32'h0};

        rst_n = 1'b0; we = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        ra0 = '0; ra1 = '0; ra2 = '0; sb_set = 1'b0; sb_set_a = '0;
        snap_req = 1'b0; snap_ready = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_snap_valid", 64'(snap_valid), 64'h0);
        check("rst_snap_idx", 64'(snap_idx), 64'h0);
        check("rst_snap_data", 64'(snap_data), 64'h0);
        check("rst_snap_last", 64'(snap_last), 64'h0);
        check("rst_snap_active", 64'(snap_active), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            we = vt[i].we; wa0 = vt[i].wa0; wa1 = vt[i].wa1; wd0 = vt[i].wd0; wd1 = vt[i].wd1;
            sb_set = vt[i].sb; sb_set_a = vt[i].sba;
            ra0 = vt[i].ra0; ra1 = vt[i].ra1; ra2 = vt[i].ra0;
            #1;
            e0 = BYP ? vt[i].exp_byp : vt[i].exp_old;
            check($sformatf("vec%0d_rd0", i), 64'(rd[0*XLEN +: XLEN]), 64'(e0));
            check($sformatf("vec%0d_rd1", i), 64'(rd[1*XLEN +: XLEN]), 64'(vt[i].exp_rd1));
            check($sformatf("vec%0d_rd2", i), 64'(rd[2*XLEN +: XLEN]), 64'(e0));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
        end

        // Preload x_i = i*0x11, alternating write ports.
        for (int i = 0; i < NUMREG; i++) exp_rf[i] = 32'(i * 32'h11);
        for (int i = 1; i < NUMREG; i++) begin
            @(negedge clk);
            sb_set = 1'b0;
            port = i % 2;
            we = (port == 0) ? 2'b01 : 2'b10;
            wa0 = 5'(i); wa1 = 5'(i); wd0 = exp_rf[i]; wd1 = exp_rf[i];
        end
        @(negedge clk);
        we = '0;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        #1;
        check("snap_active_load", 64'(snap_active), 64'h1);
        check("snap_valid_load", 64'(snap_valid), 64'h0);

        beats = 0; cyc = 0; prev_valid = 0; prev_hs = 0; live_done = 0; req2_done = 0;
        p_idx = '0; p_data = '0; p_last = 1'b0;
        while (cyc < 600 && !(beats == NUMREG && !snap_active)) begin
            @(negedge clk);
            we = '0; snap_req = 1'b0;
            snap_ready = 1'($urandom_range(0, 1));
            cyc++;
            if (beats == 10 && !req2_done) begin
                snap_req = 1'b1;
                req2_done = 1;
            end
            #1;
            if (prev_valid && !prev_hs && snap_valid) begin
                check("stall_idx", 64'(snap_idx), 64'(p_idx));
                check("stall_data", 64'(snap_data), 64'(p_data));
                check("stall_last", 64'(snap_last), 64'(p_last));
            end
            if (snap_valid && beats == 4 && !live_done) begin
                we = 2'b01; wa0 = 5'd20; wd0 = 32'hBEEF;
                exp_rf[20] = 32'hBEEF;
                live_done = 1;
            end
            hs = snap_valid && snap_ready;
            if (hs) begin
                check($sformatf("beat%0d_idx", beats), 64'(snap_idx), 64'(beats));
                check($sformatf("beat%0d_data", beats), 64'(snap_data), 64'(exp_rf[beats]));
                check($sformatf("beat%0d_last", beats), 64'(snap_last), 64'(beats == NUMREG - 1));
                beats++;
            end
            prev_valid = snap_valid; prev_hs = hs;
            p_idx = snap_idx; p_data = snap_data; p_last = snap_last;
        end
        check("snap_beats", 64'(beats), 64'(NUMREG));
        check("snap_min_cycles", 64'(cyc >= 2 * NUMREG), 64'h1);
        snap_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("post_dump_active", 64'(snap_active), 64'h0);
            check("post_dump_valid", 64'(snap_valid), 64'h0);
        end

        // Abort: dump in progress, scoreboard bit set, reset asserted at beat 10.
        @(negedge clk);
        sb_set = 1'b1; sb_set_a = 5'd4;
        ra0 = 5'd1; ra1 = 5'd2; ra2 = 5'd31;
        snap_req = 1'b1;
        @(negedge clk);
        sb_set = 1'b0; snap_req = 1'b0; snap_ready = 1'b1;
        #1;
        check("pre_abort_busy", 64'(busy), 64'h10);
        check("pre_abort_rd0", 64'(rd[0*XLEN +: XLEN]), 64'h11);
        check("pre_abort_rd2", 64'(rd[2*XLEN +: XLEN]), 64'(32'h11 * 31));
        reached = 0;
        for (int k = 0; k < 100 && !reached; k++) begin
            @(negedge clk);
            #1;
            if (snap_valid && snap_idx == 5'd10) reached = 1;
        end
        check("abort_reach_idx10", 64'(reached), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rd0", 64'(rd[0*XLEN +: XLEN]), 64'h0);
        check("abort_rd1", 64'(rd[1*XLEN +: XLEN]), 64'h0);
        check("abort_rd2", 64'(rd[2*XLEN +: XLEN]), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_valid", 64'(snap_valid), 64'h0);
        check("abort_active", 64'(snap_active), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beats = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (snap_valid) beats++;
        end
        check("abort_no_beats", 64'(beats), 64'h0);
        check("post_rst_rd0", 64'(rd[0*XLEN +: XLEN]), 64'h0);
        check("post_rst_rd2", 64'(rd[2*XLEN +: XLEN]), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
